pl_mem_stage: RTL and testbench



---
 rtl/pl_mem_stage_pkg.sv | 12 +
 rtl/mux2x32.sv | 11 +
 rtl/pl_mem_ctrl.sv | 53 +++++
 rtl/pl_mem_stage.sv | 104 ++++++++++
 tb/tb_pl_mem_stage.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/pl_mem_stage_pkg.sv
// Shared CPU constants and memory-stage FSM encoding.
package pl_mem_stage_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } mem_state_e;

endpackage

// File: rtl/mux2x32.sv
// Two-input 32-bit multiplexer.
module mux2x32 (
  input  logic [31:0] a0,
  input  logic [31:0] a1,
  input  logic        s,
  output logic [31:0] y
);

  assign y = s ? a1 : a0;

endmodule

// File: rtl/pl_mem_ctrl.sv
// Data-memory handshake FSM: request tracking, wait counter, stall and abort.
module pl_mem_ctrl
  import pl_mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clock,
  input  logic resetn,
  input  logic start,
  input  logic dack,
  output logic dreq,
  output logic mstall,
  output logic merr,
  output logic abort
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  mem_state_e state, state_n;
  logic [7:0] cnt;
  logic       access;

  assign access = (state == ST_ACCESS);

  always_comb begin
    dreq    = access;
    mstall  = access & ~dack;
    abort   = access & ~dack & (cnt == CNT_LAST);
    state_n = state;
    case (state)
      ST_IDLE:   if (start) state_n = ST_ACCESS;
      ST_ACCESS: begin
        if (dack)       state_n = start ? ST_ACCESS : ST_IDLE;
        else if (abort) state_n = ST_IDLE;
      end
      default:   state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
      cnt   <= '0;
      merr  <= 1'b0;
    end else begin
      state <= state_n;
      merr  <= abort;
      if (access && !dack && !abort) cnt <= cnt + 8'd1;
      else                           cnt <= '0;
    end
  end

endmodule

// File: rtl/pl_mem_stage.sv
// MEM stage: EXE/MEM and MEM/WB pipeline registers around the data-memory handshake.
module pl_mem_stage
  import pl_mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [DATA_W-1:0] ealu,
  input  logic [DATA_W-1:0] eb,
  input  logic [REG_W-1:0]  ern,
  input  logic              ewreg,
  input  logic              em2reg,
  input  logic              ewmem,
  input  logic [DATA_W-1:0] drdata,
  input  logic              dack,
  output logic              dreq,
  output logic              dwe,
  output logic [DATA_W-1:0] daddr,
  output logic [DATA_W-1:0] dwdata,
  output logic              mstall,
  output logic              merr,
  output logic [DATA_W-1:0] malu,
  output logic [REG_W-1:0]  mrn,
  output logic              mwreg,
  output logic              mm2reg,
  output logic [DATA_W-1:0] wmo,
  output logic [DATA_W-1:0] walu,
  output logic [REG_W-1:0]  wrn,
  output logic              wwreg,
  output logic              wm2reg,
  output logic [DATA_W-1:0] wdi
);

  logic [DATA_W-1:0] mb;
  logic              mwmem;
  logic              abort;
  logic              start;

  assign start  = ~mstall & (em2reg | ewmem);
  assign dwe    = mwmem;
  assign daddr  = malu;
  assign dwdata = mb;

  pl_mem_ctrl #(.TIMEOUT(TIMEOUT)) u_ctrl (
    .clock  (clock),
    .resetn (resetn),
    .start  (start),
    .dack   (dack),
    .dreq   (dreq),
    .mstall (mstall),
    .merr   (merr),
    .abort  (abort)
  );

  // An aborted access is turned into a bubble in place so it cannot retire once the stall lifts.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      malu   <= '0;
      mb     <= '0;
      mrn    <= '0;
      mwreg  <= 1'b0;
      mm2reg <= 1'b0;
      mwmem  <= 1'b0;
    end else if (!mstall) begin
      malu   <= ealu;
      mb     <= eb;
      mrn    <= ern;
      mwreg  <= ewreg;
      mm2reg <= em2reg;
      mwmem  <= ewmem;
    end else if (abort) begin
      mwreg  <= 1'b0;
      mm2reg <= 1'b0;
      mwmem  <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wmo    <= '0;
      walu   <= '0;
      wrn    <= '0;
      wwreg  <= 1'b0;
      wm2reg <= 1'b0;
    end else if (mstall) begin
      wwreg  <= 1'b0;
    end else begin
      walu   <= malu;
      wrn    <= mrn;
      wwreg  <= mwreg;
      wm2reg <= mm2reg;
      if (mm2reg) wmo <= drdata;
    end
  end

  mux2x32 u_wdi_mux (
    .a0 (walu),
    .a1 (wmo),
    .s  (wm2reg),
    .y  (wdi)
  );

endmodule

// File: tb/tb_pl_mem_stage.sv
// Directed self-checking bench for pl_mem_stage (TIMEOUT=4).
module tb_pl_mem_stage;

  logic        clock, resetn;
  logic [31:0] ealu, eb, drdata;
  logic [4:0]  ern;
  logic        ewreg, em2reg, ewmem, dack;
  logic        dreq, dwe, mstall, merr, mwreg, mm2reg, wwreg, wm2reg;
  logic [31:0] daddr, dwdata, malu, wmo, walu, wdi;
  logic [4:0]  mrn, wrn;

  int unsigned tests;
  int unsigned fails;

  pl_mem_stage #(.TIMEOUT(4)) dut (
    .clock  (clock),  .resetn (resetn),
    .ealu   (ealu),   .eb     (eb),     .ern    (ern),
    .ewreg  (ewreg),  .em2reg (em2reg), .ewmem  (ewmem),
    .drdata (drdata), .dack   (dack),
    .dreq   (dreq),   .dwe    (dwe),    .daddr  (daddr),  .dwdata (dwdata),
    .mstall (mstall), .merr   (merr),
    .malu   (malu),   .mrn    (mrn),    .mwreg  (mwreg),  .mm2reg (mm2reg),
    .wmo    (wmo),    .walu   (walu),   .wrn    (wrn),
    .wwreg  (wwreg),  .wm2reg (wm2reg), .wdi    (wdi)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic bubble();
    ealu = '0; eb = '0; ern = '0; ewreg = 1'b0; em2reg = 1'b0; ewmem = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    resetn = 1'b0;
    drdata = '0;
    dack   = 1'b0;
    bubble();

    // reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_dreq", 32'(dreq), 32'd0);
    chk("rst_mstall", 32'(mstall), 32'd0);
    chk("rst_merr", 32'(merr), 32'd0);
    chk("rst_wwreg", 32'(wwreg), 32'd0);
    chk("rst_malu", malu, 32'd0);
    chk("rst_wdi", wdi, 32'd0);
    resetn = 1'b1;

    // ALU op; dack high with dreq low must be ignored
    ealu = 32'h1234; ern = 5'd5; ewreg = 1'b1; dack = 1'b1;
    #1;
    chk("alu_mstall0", 32'(mstall), 32'd0);
    tick();
    chk("alu_malu", malu, 32'h1234);
    chk("alu_mrn", 32'(mrn), 32'd5);
    chk("alu_dreq", 32'(dreq), 32'd0);
    chk("alu_mstall", 32'(mstall), 32'd0);
    bubble();
    tick();
    chk("alu_walu", walu, 32'h1234);
    chk("alu_wrn", 32'(wrn), 32'd5);
    chk("alu_wwreg", 32'(wwreg), 32'd1);
    chk("alu_wdi", wdi, 32'h1234);

    // zero-wait load
    ealu = 32'h40; em2reg = 1'b1; ern = 5'd8; ewreg = 1'b1; drdata = 32'hDEADBEEF;
    tick();
    chk("ld_dreq", 32'(dreq), 32'd1);
    chk("ld_dwe", 32'(dwe), 32'd0);
    chk("ld_mstall", 32'(mstall), 32'd0);
    chk("ld_daddr", daddr, 32'h40);
    bubble();
    tick();
    chk("ld_wmo", wmo, 32'hDEADBEEF);
    chk("ld_wdi", wdi, 32'hDEADBEEF);
    chk("ld_wrn", 32'(wrn), 32'd8);
    chk("ld_wwreg", 32'(wwreg), 32'd1);
    chk("ld_dreq_done", 32'(dreq), 32'd0);
    dack = 1'b0;

    // store with 3 wait cycles; dack arrives on the timeout-terminal cycle
    ealu = 32'h80; eb = 32'hCAFE0001; ewmem = 1'b1;
    tick();
    bubble();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("st_mstall%0d", i), 32'(mstall), 32'd1);
      chk($sformatf("st_dreq%0d", i), 32'(dreq), 32'd1);
      chk($sformatf("st_dwe%0d", i), 32'(dwe), 32'd1);
      chk($sformatf("st_daddr%0d", i), daddr, 32'h80);
      chk($sformatf("st_dwdata%0d", i), dwdata, 32'hCAFE0001);
      tick();
      chk($sformatf("st_bubble%0d", i), 32'(wwreg), 32'd0);
    end
    dack = 1'b1;
    #1;
    chk("st_ack_mstall", 32'(mstall), 32'd0);
    chk("st_ack_daddr", daddr, 32'h80);
    tick();
    chk("st_retire_wwreg", 32'(wwreg), 32'd0);
    chk("st_merr", 32'(merr), 32'd0);
    chk("st_dreq_done", 32'(dreq), 32'd0);

    // back-to-back loads, dack high
    ealu = 32'h100; em2reg = 1'b1; ewreg = 1'b1; ern = 5'd9;
    tick();
    chk("b2b_dreq0", 32'(dreq), 32'd1);
    chk("b2b_daddr0", daddr, 32'h100);
    chk("b2b_mstall0", 32'(mstall), 32'd0);
    ealu = 32'h104; ern = 5'd10; drdata = 32'h11111111;
    tick();
    chk("b2b_dreq1", 32'(dreq), 32'd1);
    chk("b2b_daddr1", daddr, 32'h104);
    chk("b2b_mstall1", 32'(mstall), 32'd0);
    chk("b2b_wmo0", wmo, 32'h11111111);
    chk("b2b_wrn0", 32'(wrn), 32'd9);
    bubble();
    drdata = 32'h22222222;
    tick();
    chk("b2b_wmo1", wmo, 32'h22222222);
    chk("b2b_wrn1", 32'(wrn), 32'd10);
    chk("b2b_wwreg1", 32'(wwreg), 32'd1);
    chk("b2b_dreq_done", 32'(dreq), 32'd0);
    dack = 1'b0;

    // timeout: load never acknowledged, ALU waits behind it
    ealu = 32'h200; em2reg = 1'b1; ewreg = 1'b1; ern = 5'd3;
    tick();
    bubble();
    ealu = 32'h55; ern = 5'd4; ewreg = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("to_mstall%0d", i), 32'(mstall), 32'd1);
      chk($sformatf("to_merr%0d", i), 32'(merr), 32'd0);
      tick();
      chk($sformatf("to_bubble%0d", i), 32'(wwreg), 32'd0);
    end
    chk("to_merr", 32'(merr), 32'd1);
    chk("to_dreq", 32'(dreq), 32'd0);
    chk("to_mstall_end", 32'(mstall), 32'd0);
    tick();
    chk("to_merr_pulse", 32'(merr), 32'd0);
    chk("to_retire_wwreg", 32'(wwreg), 32'd0);
    chk("to_next_malu", malu, 32'h55);
    bubble();
    tick();
    chk("to_next_walu", walu, 32'h55);
    chk("to_next_wrn", 32'(wrn), 32'd4);
    chk("to_next_wwreg", 32'(wwreg), 32'd1);

    // reset asserted mid-access
    ealu = 32'h77; ern = 5'd6; ewreg = 1'b1;
    tick();
    ealu = 32'h300; em2reg = 1'b1; ewreg = 1'b1; ern = 5'd7;
    tick();
    chk("mr_dreq_pre", 32'(dreq), 32'd1);
    chk("mr_walu_pre", walu, 32'h77);
    bubble();
    #2;
    resetn = 1'b0;
    #1;
    chk("mr_dreq", 32'(dreq), 32'd0);
    chk("mr_mstall", 32'(mstall), 32'd0);
    chk("mr_wwreg", 32'(wwreg), 32'd0);
    chk("mr_walu", walu, 32'd0);
    chk("mr_wrn", 32'(wrn), 32'd0);
    chk("mr_wdi", wdi, 32'd0);
    #1;
    resetn = 1'b1;
    ealu = 32'h99; ern = 5'd2; ewreg = 1'b1;
    tick();
    bubble();
    chk("mr_post_dreq", 32'(dreq), 32'd0);
    tick();
    chk("mr_post_walu", walu, 32'h99);
    chk("mr_post_wwreg", 32'(wwreg), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
